mips_shift_seq: RTL and testbench

//   Multi-cycle shift sequencer for the MIPS datapath: executes SLL/SRL/SRA by a variable amount.

---
 rtl/mips_shift_seq.sv | 146 ++++++++++++++
 tb/tb_mips_shift_seq.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/mips_shift_seq.sv
// -----------------------------------------------------------------------------
// mips_shift_seq
//   Multi-cycle shift sequencer for the MIPS datapath. Executes SLL, SRL and
//   SRA by a variable amount. Instead of a full barrel shifter, a small
//   shifter moves the operand by at most STEP bits per cycle.
//
//   A request is taken on a valid/ready handshake (i_Start_Valid/o_Start_Ready).
//   The result is returned on a second valid/ready handshake
//   (o_Result_Valid/i_Result_Ready).
//
// Ports
//   i_clk           rising-edge clock
//   i_reset         synchronous, active-high reset
//   i_Start_Valid   request present
//   o_Start_Ready   request can be accepted (high only in IDLE)
//   i_Op            00 SLL, 01 SRL, 10 SRA, 11 SLL
//   i_Data1         operand
//   i_Shamt         unsigned shift amount
//   o_Result_Valid  o_Out holds the final result
//   i_Result_Ready  consumer takes the result
//   o_Out           shifted result (zero outside DONE)
//   o_Busy          sequencer is not in IDLE
// -----------------------------------------------------------------------------
module mips_shift_seq #(
   parameter int WIDTH   = 32,
   parameter int SHAMT_W = 5,
   parameter int STEP    = 2
) (
   input  logic               i_clk,
   input  logic               i_reset,
   input  logic               i_Start_Valid,
   output logic               o_Start_Ready,
   input  logic [1:0]         i_Op,
   input  logic [WIDTH-1:0]   i_Data1,
   input  logic [SHAMT_W-1:0] i_Shamt,
   output logic               o_Result_Valid,
   input  logic               i_Result_Ready,
   output logic [WIDTH-1:0]   o_Out,
   output logic               o_Busy
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

   // When STEP == WIDTH this truncates to zero, but then r_rem can never
   // exceed STEP, so the truncated value is never selected.
   localparam logic [SHAMT_W-1:0] STEP_N = SHAMT_W'(STEP);

   state_t               r_state;
   state_t               w_state_nxt;
   logic [WIDTH-1:0]     r_acc;
   logic [WIDTH-1:0]     w_acc_nxt;
   logic [1:0]           r_op;
   logic [1:0]           w_op_nxt;
   logic [SHAMT_W-1:0]   r_rem;
   logic [SHAMT_W-1:0]   w_rem_nxt;
   logic [SHAMT_W-1:0]   w_n;
   logic                 r_result_valid;
   logic [WIDTH-1:0]     r_out;

   // One step of the iterative shifter. n never exceeds STEP.
   function automatic logic [WIDTH-1:0] f_shift_step(
      input logic [1:0]         op,
      input logic [WIDTH-1:0]   acc,
      input logic [SHAMT_W-1:0] n
   );
      logic signed [WIDTH-1:0] s_acc;
      logic signed [WIDTH-1:0] s_res;
      logic [WIDTH-1:0]        res;
      s_acc = acc;
      s_res = s_acc >>> n;
      case (op)
         2'b01:   res = acc >> n;
         2'b10:   res = s_res;
         default: res = acc << n;
      endcase
      return res;
   endfunction

   // Next-state and datapath decode
   always_comb begin
      w_state_nxt = r_state;
      w_acc_nxt   = r_acc;
      w_op_nxt    = r_op;
      w_rem_nxt   = r_rem;
      w_n         = (int'(r_rem) > STEP) ? STEP_N : r_rem;

      case (r_state)
         IDLE: begin
            if (i_Start_Valid) begin
               w_acc_nxt   = i_Data1;
               w_op_nxt    = i_Op;
               w_rem_nxt   = i_Shamt;
               w_state_nxt = (i_Shamt == '0) ? DONE : SHIFT;
            end
         end
         SHIFT: begin
            w_acc_nxt = f_shift_step(r_op, r_acc, w_n);
            w_rem_nxt = r_rem - w_n;
            // This step consumes the remainder entirely.
            if (int'(r_rem) <= STEP) begin
               w_state_nxt = DONE;
            end
         end
         DONE: begin
            if (i_Result_Ready) begin
               w_state_nxt = IDLE;
            end
         end
         default: begin
            w_state_nxt = IDLE;
         end
      endcase
   end

   // Control state and registered result outputs
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_state        <= IDLE;
         r_result_valid <= 1'b0;
         r_out          <= '0;
      end else begin
         r_state        <= w_state_nxt;
         // The result outputs are a registered image of the DONE state, so
         // o_Out is zero everywhere else and no stale value survives a reset.
         r_result_valid <= (w_state_nxt == DONE);
         r_out          <= (w_state_nxt == DONE) ? w_acc_nxt : '0;
      end
   end

   // Operand datapath; contents are only meaningful after an accept
   always_ff @(posedge i_clk) begin
      r_acc <= w_acc_nxt;
      r_op  <= w_op_nxt;
      r_rem <= w_rem_nxt;
   end

   assign o_Start_Ready  = (r_state == IDLE);
   assign o_Busy         = (r_state != IDLE);
   assign o_Result_Valid = r_result_valid;
   assign o_Out          = r_out;

endmodule

// File: tb/tb_mips_shift_seq.sv
module tb_mips_shift_seq;

   localparam int WIDTH   = 32;
   localparam int SHAMT_W = 5;
   localparam int STEP    = 2;

   logic              clk = 1'b0;
   logic              reset;
   logic              start_valid;
   logic              start_ready;
   logic [1:0]        op;
   logic [WIDTH-1:0]  data1;
   logic [SHAMT_W-1:0] shamt;
   logic              result_valid;
   logic              result_ready;
   logic [WIDTH-1:0]  out_w;
   logic              busy;

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   mips_shift_seq #(.WIDTH(WIDTH), .SHAMT_W(SHAMT_W), .STEP(STEP)) dut (
      .i_clk          (clk),
      .i_reset        (reset),
      .i_Start_Valid  (start_valid),
      .o_Start_Ready  (start_ready),
      .i_Op           (op),
      .i_Data1        (data1),
      .i_Shamt        (shamt),
      .o_Result_Valid (result_valid),
      .i_Result_Ready (result_ready),
      .o_Out          (out_w),
      .o_Busy         (busy)
   );

   typedef struct {
      logic [1:0]  op;
      logic [31:0] data;
      logic [4:0]  shamt;
      logic [31:0] exp_out;
      int          exp_lat;
   } vec_t;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got=0x%08h expected=0x%08h", name, act, exp);
      end
   endtask

   // Single-cycle reference: multiply/divide by a power of two, with floor
   // division on the signed value for the arithmetic right shift.
   function automatic logic [31:0] ref_shift(input logic [1:0] o, input logic [31:0] d, input int s);
      longint unsigned ud;
      longint          sv;
      longint          p;
      longint          q;
      p = longint'(1) << s;
      if (o == 2'b01) begin
         ud = longint'(d);
         ud = ud / longint'(p);
         return ud[31:0];
      end else if (o == 2'b10) begin
         sv = longint'($signed(d));
         q  = sv / p;
         if (sv < 0 && q * p != sv) q = q - 1;
         return q[31:0];
      end else begin
         ud = longint'(d) * longint'(p);
         return ud[31:0];
      end
   endfunction

   function automatic int ref_lat(input int s);
      return 1 + (s + STEP - 1) / STEP;
   endfunction

   // Called #1 after a rising edge with the sequencer in IDLE.
   task automatic do_op(input logic [1:0] o, input logic [31:0] d, input logic [4:0] s,
                        input int rr_delay, input string tag,
                        input logic [31:0] exp, input int exp_lat);
      int   lat;
      logic zero_ok;
      check({tag, "_start_ready"}, {31'd0, start_ready}, 32'd1);
      op = o; data1 = d; shamt = s; start_valid = 1'b1;
      @(posedge clk); #1;
      // Scramble the request inputs; they must have been captured already.
      start_valid = 1'b0;
      op = 2'($urandom); data1 = $urandom; shamt = 5'($urandom);
      lat = 1;
      zero_ok = 1'b1;
      while (!result_valid && lat < 100) begin
         if (out_w !== '0) zero_ok = 1'b0;
         @(posedge clk); #1;
         lat++;
      end
      check({tag, "_latency"}, 32'(lat), 32'(exp_lat));
      check({tag, "_out"}, out_w, exp);
      check({tag, "_out_zero_before_done"}, {31'd0, zero_ok}, 32'd1);
      repeat (rr_delay) begin
         @(posedge clk); #1;
      end
      result_ready = 1'b1;
      @(posedge clk); #1;
      result_ready = 1'b0;
      check({tag, "_rv_after_take"}, {31'd0, result_valid}, 32'd0);
   endtask

   vec_t vecs[8];

   initial begin
      int   lat;
      logic seen;

      vecs[0] = '{2'b00, 32'h0000_0001,  5'd2, 32'h0000_0004,  2};
      vecs[1] = '{2'b10, 32'h8000_0000, 5'd31, 32'hFFFF_FFFF, 17};
      vecs[2] = '{2'b01, 32'h8000_0000, 5'd31, 32'h0000_0001, 17};
      vecs[3] = '{2'b11, 32'h0000_FFFF, 5'd16, 32'hFFFF_0000,  9};
      vecs[4] = '{2'b10, 32'hDEAD_BEEF,  5'd0, 32'hDEAD_BEEF,  1};
      vecs[5] = '{2'b10, 32'h7FFF_FFFF, 5'd31, 32'h0000_0000, 17};
      vecs[6] = '{2'b01, 32'hF000_0000,  5'd1, 32'h7800_0000,  2};
      vecs[7] = '{2'b10, 32'hF000_0000,  5'd3, 32'hFE00_0000,  3};

      reset = 1'b1; start_valid = 1'b0; result_ready = 1'b0;
      op = '0; data1 = '0; shamt = '0;
      repeat (2) @(posedge clk);
      #1;
      check("reset_start_ready", {31'd0, start_ready}, 32'd1);
      check("reset_busy", {31'd0, busy}, 32'd0);
      check("reset_result_valid", {31'd0, result_valid}, 32'd0);
      check("reset_out", out_w, 32'd0);
      reset = 1'b0;

      for (int i = 0; i < 8; i++) begin
         do_op(vecs[i].op, vecs[i].data, vecs[i].shamt, i % 3,
               $sformatf("vec%0d", i), vecs[i].exp_out, vecs[i].exp_lat);
      end

      // Result held while the consumer stalls and a new request waits.
      op = 2'b00; data1 = 32'h1234_5678; shamt = 5'd4; start_valid = 1'b1;
      @(posedge clk); #1;
      op = 2'b01; data1 = 32'hA5A5_0000; shamt = 5'd8;
      lat = 0;
      while (!result_valid && lat < 50) begin
         @(posedge clk); #1;
         lat++;
      end
      for (int i = 0; i < 5; i++) begin
         check($sformatf("hold%0d_out", i), out_w, 32'h2345_6780);
         check($sformatf("hold%0d_rv", i), {31'd0, result_valid}, 32'd1);
         check($sformatf("hold%0d_start_ready", i), {31'd0, start_ready}, 32'd0);
         @(posedge clk); #1;
      end
      result_ready = 1'b1;
      @(posedge clk); #1;
      result_ready = 1'b0;
      check("hold_idle_start_ready", {31'd0, start_ready}, 32'd1);
      check("hold_idle_busy", {31'd0, busy}, 32'd0);
      @(posedge clk); #1;
      start_valid = 1'b0;
      check("hold_next_accepted", {31'd0, busy}, 32'd1);
      lat = 1;
      while (!result_valid && lat < 50) begin
         @(posedge clk); #1;
         lat++;
      end
      check("hold_next_latency", 32'(lat), 32'(ref_lat(8)));
      check("hold_next_out", out_w, 32'h00A5_A500);
      result_ready = 1'b1;
      @(posedge clk); #1;
      result_ready = 1'b0;

      // Reset in the third SHIFT cycle abandons the operation.
      op = 2'b00; data1 = 32'h0000_0001; shamt = 5'd31; start_valid = 1'b1;
      @(posedge clk); #1;
      start_valid = 1'b0;
      repeat (2) begin
         @(posedge clk); #1;
      end
      check("midreset_busy_before", {31'd0, busy}, 32'd1);
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      check("midreset_start_ready", {31'd0, start_ready}, 32'd1);
      check("midreset_busy", {31'd0, busy}, 32'd0);
      check("midreset_out", out_w, 32'd0);
      check("midreset_rv", {31'd0, result_valid}, 32'd0);
      seen = 1'b0;
      repeat (25) begin
         @(posedge clk); #1;
         if (result_valid || out_w !== '0) seen = 1'b1;
      end
      check("midreset_no_stale_result", {31'd0, seen}, 32'd0);

      // Randomised operations against the reference model.
      for (int i = 0; i < 40; i++) begin
         logic [1:0]  ro;
         logic [31:0] rd;
         int          rs;
         ro = 2'($urandom_range(0, 3));
         rd = $urandom;
         rs = $urandom_range(0, 31);
         do_op(ro, rd, 5'(rs), $urandom_range(0, 3), $sformatf("rnd%0d", i),
               ref_shift(ro, rd, rs), ref_lat(rs));
      end

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
